// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : Request/response bundle between the CPU load/store path
//               (master) and the data-memory responder (slave).
//               Request channel : req_valid, req_ready, req_addr, req_wr,
//                                 req_wdata
//               Response channel: resp_valid, resp_ready, resp_rdata,
//                                 resp_err
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        req_wr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  // CPU side: issues requests, consumes responses.
  modport master (
    output req_valid, req_addr, req_wr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  // Memory side: accepts requests, produces responses.
  modport slave (
    input  req_valid, req_addr, req_wr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder for the CPU data port. Accepts one
//               load/store request at a time over a valid/ready handshake,
//               performs the array access at the acceptance edge and
//               presents the response LATENCY edges later. Backing store is
//               DEPTH_WORDS x 64-bit words, byte addressed, word aligned.
// Ports       : clk  - clock, all state updates on posedge
//               rst  - synchronous active-high reset
//               bus  - dmem_responder_if.slave (request + response channels)
// Parameters  : DEPTH_WORDS - number of 64-bit words (power of 2, >= 2)
//               LATENCY     - edges from acceptance to resp_valid (>= 1)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  wire              clk,
  input  wire              rst,
  dmem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [63:0]        rdata_q, rdata_d;
  logic               err_q,   err_d;

  logic [63:0]        mem_q [DEPTH_WORDS];

  logic               accept;
  logic               addr_err;
  logic [IDX_W-1:0]   word_idx;
  logic               mem_we;

  // Ready depends on state only, so there is no path from req_valid.
  assign bus.req_ready = (state_q == S_IDLE);
  assign accept        = bus.req_valid && (state_q == S_IDLE);

  // Any set bit above the word-index field means the byte address is at or
  // beyond DEPTH_WORDS*8; low three bits must be zero for a 64-bit access.
  assign word_idx = bus.req_addr[3 +: IDX_W];
  assign addr_err = (bus.req_addr[2:0] != 3'b000) ||
                    (|bus.req_addr[63:IDX_W+3]);

  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  // --------------------------------------------------------------------------
  // Next-state / datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          err_d  = addr_err;
          mem_we = !addr_err && bus.req_wr;
          // Read data is captured now; stores and errors report zero.
          if (addr_err || bus.req_wr) begin
            rdata_d = 64'd0;
          end else begin
            rdata_d = mem_q[word_idx];
          end
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
          rdata_d = 64'd0;
          err_d   = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        rdata_d = 64'd0;
        err_d   = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Control / response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Backing store: not cleared by reset. The write commits at the acceptance
  // edge, so a later reset does not undo it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[word_idx] <= bus.req_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder (LATENCY=3,
//               DEPTH_WORDS=1024). A flat word array models the store; each
//               transaction's expected response is derived from address
//               arithmetic on that array.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int LAT   = 3;
  localparam int DEPTH = 1024;
  localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'd8;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   cyc;

  logic [63:0] ref_mem [DEPTH];

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_err(input logic [63:0] a);
    return (a % 64'd8 != 64'd0) || (a >= LIMIT);
  endfunction

  // Applies the request to the reference array and returns the expected
  // response fields.
  task automatic model_apply(input logic [63:0] a, input logic w, input logic [63:0] d,
                             output logic [63:0] exp_rdata, output logic exp_err);
    exp_err   = model_err(a);
    exp_rdata = 64'd0;
    if (!exp_err) begin
      if (w) ref_mem[int'(a / 64'd8)] = d;
      else   exp_rdata = ref_mem[int'(a / 64'd8)];
    end
  endtask

  // One complete transaction: wait for ready, accept, check latency, hold
  // the response for 'hold' cycles of back-pressure, then hand it off.
  task automatic xact(input string tag, input logic [63:0] a, input logic w,
                      input logic [63:0] d, input int hold);
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          n;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_wr    = w;
    bus.req_wdata = d;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_ready_to"}, 64'(n < 50), 64'd1);
    tick();                                   // acceptance edge
    model_apply(a, w, d, exp_rdata, exp_err);
    // Keep presenting a garbage store; it must be ignored while not ready.
    bus.req_wr    = 1'b1;
    bus.req_addr  = 64'($urandom_range(0, 15)) * 64'd8;
    bus.req_wdata = {$urandom, $urandom};
    n = 0;
    while (!bus.resp_valid && n < 50) begin
      check({tag, "_busy_ready"}, 64'(bus.req_ready), 64'd0);
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(LAT - 1));
    check({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
    check({tag, "_err"}, 64'(bus.resp_err), 64'(exp_err));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_bp_valid"}, 64'(bus.resp_valid), 64'd1);
      check({tag, "_bp_rdata"}, bus.resp_rdata, exp_rdata);
      check({tag, "_bp_err"}, 64'(bus.resp_err), 64'(exp_err));
      check({tag, "_bp_ready"}, 64'(bus.req_ready), 64'd0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    tick();                                   // handshake edge
    bus.resp_ready = 1'b0;
    check({tag, "_done_valid"}, 64'(bus.resp_valid), 64'd0);
    check({tag, "_done_rdata"}, bus.resp_rdata, 64'd0);
    check({tag, "_done_ready"}, 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] q_rdata [$];
    logic        q_err   [$];
    logic [63:0] b2b_addr [6];
    logic        b2b_wr   [6];
    logic [63:0] b2b_data [6];
    logic [63:0] er;
    logic        ee;
    logic        rdy_before;
    int          idx;
    int          last_acc;
    int          guard;

    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 64'd0;

    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = 64'd0;
    bus.req_wr     = 1'b0;
    bus.req_wdata  = 64'd0;
    bus.resp_ready = 1'b0;

    // Reset for two edges.
    tick();
    tick();
    rst = 1'b0;
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_rdata", bus.resp_rdata, 64'd0);
    check("rst_resp_err", 64'(bus.resp_err), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);

    // Store then load the same word.
    xact("st40", 64'h40, 1'b1, 64'hDEADBEEF_CAFEF00D, 0);
    xact("ld40", 64'h40, 1'b0, 64'h0, 0);

    // Error cases, then prove no write happened.
    xact("ld44_mis", 64'h44, 1'b0, 64'h0, 0);
    xact("st2003_mis", 64'h2003, 1'b1, 64'h1, 0);
    xact("st2000_oor", 64'h2000, 1'b1, 64'h1, 0);
    xact("ld0_nowrite", 64'h0, 1'b0, 64'h0, 0);

    // Highest valid word, and back-pressure on a load.
    xact("st1ff8", 64'h1FF8, 1'b1, 64'h0123_4567_89AB_CDEF, 0);
    xact("ld1ff8_bp", 64'h1FF8, 1'b0, 64'h0, 5);

    // Reset while waiting: response abandoned, store already committed.
    bus.req_valid = 1'b1;
    bus.req_addr  = 64'h80;
    bus.req_wr    = 1'b1;
    bus.req_wdata = 64'h55;
    check("rm_ready", 64'(bus.req_ready), 64'd1);
    tick();                                   // acceptance edge
    model_apply(64'h80, 1'b1, 64'h55, er, ee);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rm_valid_after_rst", 64'(bus.resp_valid), 64'd0);
    check("rm_ready_after_rst", 64'(bus.req_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rm_no_resp", 64'(bus.resp_valid), 64'd0);
    end
    xact("ld80_after_rst", 64'h80, 1'b0, 64'h0, 0);

    // Back-to-back with req_valid and resp_ready held high.
    b2b_addr = '{64'h0, 64'h8, 64'h10, 64'h10, 64'h8, 64'h0};
    b2b_wr   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) b2b_data[i] = {$urandom, $urandom};
    idx      = 0;
    last_acc = -1;
    guard    = 0;
    bus.req_valid  = 1'b1;
    bus.req_addr   = b2b_addr[0];
    bus.req_wr     = b2b_wr[0];
    bus.req_wdata  = b2b_data[0];
    bus.resp_ready = 1'b1;
    while ((idx < 6 || q_rdata.size() > 0) && guard < 200) begin
      rdy_before = bus.req_ready;
      if (bus.resp_valid) begin
        if (q_rdata.size() == 0) begin
          check("b2b_spurious_resp", 64'd1, 64'd0);
        end else begin
          check("b2b_rdata", bus.resp_rdata, q_rdata.pop_front());
          check("b2b_err", 64'(bus.resp_err), 64'(q_err.pop_front()));
        end
      end
      tick();
      guard++;
      if (rdy_before && idx < 6) begin
        model_apply(b2b_addr[idx], b2b_wr[idx], b2b_data[idx], er, ee);
        q_rdata.push_back(er);
        q_err.push_back(ee);
        if (last_acc >= 0) check("b2b_spacing", 64'(cyc - last_acc), 64'(LAT + 1));
        last_acc = cyc;
        idx++;
        if (idx < 6) begin
          bus.req_addr  = b2b_addr[idx];
          bus.req_wr    = b2b_wr[idx];
          bus.req_wdata = b2b_data[idx];
        end else begin
          bus.req_valid = 1'b0;
        end
      end
    end
    check("b2b_timeout", 64'(guard < 200), 64'd1);
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    tick();

    // Randomized traffic concentrated on a small window for read-after-write
    // hits, with occasional misaligned, out-of-range and top-word accesses.
    for (int t = 0; t < 40; t++) begin
      logic [63:0] a;
      int          sel;
      sel = int'($urandom_range(0, 9));
      if (sel <= 6)      a = 64'($urandom_range(0, 15)) * 64'd8;
      else if (sel == 7) a = 64'($urandom_range(0, 15)) * 64'd8 + 64'($urandom_range(1, 7));
      else if (sel == 8) a = LIMIT + 64'($urandom_range(0, 1000)) * 64'd8;
      else               a = LIMIT - 64'd8;
      xact("rnd", a, 1'($urandom_range(0, 1)), {$urandom, $urandom},
           int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far end of the CPU data port. It serves load/store requests from the CPU's load/store path.
- Turns the CPU's address / write-enable / write-data outputs into a valid/ready request-response transaction with configurable access latency.
- Backing store is 64-bit words, byte-addressed, with one outstanding request at a time.
- Gives the pipelined CPU a realistic multi-cycle memory to stall on, replacing the zero-latency combinational memory model.

Parameters:
- DEPTH_WORDS, 1024, number of 64-bit words in the store (power of 2, ≥ 2).
- LATENCY, 2, clock edges from request acceptance to resp_valid assertion (≥ 1).

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  1  CPU presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_addr  input  64  byte address.
- req_wr  input  1  1 = store (STUR), 0 = load (LDUR).
- req_wdata  input  64  store data.
- resp_valid  output  1  response available.
- resp_ready  input  1  CPU consumes the response.
- resp_rdata  output  64  load data; 0 for stores and errors.
- resp_err  output  1  request was misaligned or out of range.

Behaviour:
- Reset (rst high at posedge):
  - State goes to IDLE; resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
  - req_ready=1 in the cycle after reset.
  - Storage array contents are NOT cleared by rst; the array is zero at time 0 in simulation.
- Reset mid-operation: any accepted-but-unresponded request is abandoned. A store already committed at its acceptance edge stays written.
- Acceptance: a request is accepted at a posedge where req_valid && req_ready. req_ready is 1 only in IDLE and is a function of state only, with no combinational path from req_valid.
- Address check, evaluated at acceptance:
  - err = (req_addr[2:0] != 0) || (req_addr >= DEPTH_WORDS*8).
  - Word index = req_addr[3 +: log2(DEPTH_WORDS)].
- At the acceptance edge:
  - Store, no error: word written with req_wdata (full 64 bits, no byte enables); response data latched as 0.
  - Load, no error: word read and latched as response data.
  - Error: no array write; response data latched as 0, err latched as 1.
- State machine:
  - IDLE: on acceptance, go to RESP if LATENCY==1, else go to WAIT with counter = LATENCY-1.
  - WAIT: counter decrements each edge; when counter==1 at an edge, go to RESP.
  - RESP: resp_valid=1, and resp_rdata/resp_err hold the latched values, stable until handshake. On resp_valid && resp_ready at a posedge, go to IDLE and clear resp_valid/resp_rdata/resp_err.
- Latency: request accepted at edge T → resp_valid is 1 in the cycle following edge T+LATENCY-1. For LATENCY=2, resp_valid is first high after edge T+1.
- Back-pressure: if resp_ready stays low, RESP holds indefinitely and req_ready stays 0.
- No same-cycle overlap: the edge that completes a response returns to IDLE. The next request is accepted no earlier than the following edge, so peak throughput is 1 request per LATENCY+1 cycles.
- Requests held with req_valid=1 while req_ready=0 are ignored; nothing is sampled.
- Read-after-write: a load accepted after a store to the same word returns the stored value. This holds because only one request is outstanding at a time.
- Inputs req_addr/req_wr/req_wdata matter only at the acceptance edge.

Test Plan:
- Reset then store/load: rst for 2 cycles; store addr 0x40 data 0xDEADBEEF_CAFEF00D; then load 0x40 → resp_rdata=0xDEADBEEFCAFEF00D, resp_err=0. Store response has rdata=0, err=0.
- Latency check, LATENCY=3: load accepted at edge T → resp_valid low after T+1, high after edge T+2. req_ready low from after T until the edge after the resp handshake.
- Errors: load 0x44 → err=1, rdata=0. Store 0x2003 data 0x1 → err=1. Store 0x2000 (=DEPTH_WORDS*8 for 1024) → err=1. Subsequent load 0x0 returns the prior contents (0 after time 0), proving no write occurred.
- Back-pressure: hold resp_ready=0 for 5 cycles after resp_valid → resp_valid, resp_rdata and resp_err stay stable and req_ready=0 throughout. Raise resp_ready → resp_valid drops after that edge.
- Reset mid-operation: accept store 0x80 data 0x55, assert rst during WAIT → resp_valid never asserts and req_ready=1 after reset. A load of 0x80 returns 0x55.
- Back-to-back: stores to 0x0, 0x8, 0x10 then loads in reverse order with resp_ready tied 1 → each request accepted exactly LATENCY+1 cycles apart and loads return the correct values. req_valid held high between grants causes no extra accepts.
